// File: rtl/neuron_mac_preact_pkg.sv
// Shared types and defaults for the neuron MAC pre-activation stage.
// Fixed-point defaults, FSM state encoding and a counter-width helper.
package neuron_mac_preact_pkg;

  localparam int DEF_N   = 32;
  localparam int DEF_Q   = 16;
  localparam int DEF_LEN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_FINAL,
    S_OUT
  } state_t;

  function automatic int cnt_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/neuron_mac_preact_if.sv
// Beat input and result output handshakes of the neuron MAC stage.
// master drives beats and accepts results; slave is the MAC itself.
interface neuron_mac_preact_if #(
  parameter int N = 32
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] w;
  logic [N-1:0] pre_act;
  logic         out_valid;
  logic         out_ready;
  logic         sat;

  modport master (
    output in_valid, x, w, out_ready,
    input  in_ready, pre_act, out_valid, sat
  );

  modport slave (
    input  in_valid, x, w, out_ready,
    output in_ready, pre_act, out_valid, sat
  );

endinterface

// File: rtl/neuron_mac_preact_smul.sv
// Registered signed N x N -> 2N multiplier with load enable.
// Product register holds its value while en is low.
module fxp_smul_reg #(
  parameter int N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N-1:0]          a,
  input  logic [N-1:0]          b,
  output logic signed [2*N-1:0] p
);

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;

  assign a_ext = {{N{a[N-1]}}, a};
  assign b_ext = {{N{b[N-1]}}, b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= '0;
    end else if (en) begin
      p <= a_ext * b_ext;
    end
  end

endmodule

// File: rtl/neuron_mac_preact.sv
// Streaming fixed-point MAC for one dense-layer neuron.
// Accumulates LEN x*w beats onto the bias, then rounds and saturates.
module neuron_mac_preact
  import neuron_mac_preact_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int Q     = DEF_Q,
  parameter int LEN   = DEF_LEN,
  parameter int ACC_W = 2*N + $clog2(LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       bias,
  output logic               busy,
  neuron_mac_preact_if.slave io
);

  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  localparam logic [N-1:0] FXP_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] FXP_MIN = {1'b1, {(N-1){1'b0}}};

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(1) << (Q - 1);
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [2*N-1:0]   prod;
  logic                    prod_vld;
  logic                    beat;
  logic [N-1:0]            pre_act;
  logic                    out_valid;
  logic                    sat;

  assign beat         = io.in_valid && (state == S_ACCUM);
  assign io.in_ready  = (state == S_ACCUM);
  assign busy         = (state != S_IDLE);
  assign io.pre_act   = pre_act;
  assign io.out_valid = out_valid;
  assign io.sat       = sat;

  assign prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
  assign bias_ext = {{(ACC_W-N-Q){bias[N-1]}}, bias, {Q{1'b0}}};

  // round half toward +inf, then drop the Q extra fraction bits
  assign r = (acc + HALF) >>> Q;

  fxp_smul_reg #(
    .N(N)
  ) u_mul (
    .clk(clk),
    .rst(rst),
    .en (beat),
    .a  (io.x),
    .b  (io.w),
    .p  (prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      prod_vld  <= 1'b0;
      pre_act   <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      prod_vld <= beat;
      if (prod_vld) begin
        acc <= acc + prod_ext;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            cnt   <= '0;
            state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= S_DRAIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          state <= S_FINAL;
        end
        S_FINAL: begin
          if (r > SMAX) begin
            pre_act <= FXP_MAX;
            sat     <= 1'b1;
          end else if (r < SMIN) begin
            pre_act <= FXP_MIN;
            sat     <= 1'b1;
          end else begin
            pre_act <= r[N-1:0];
            sat     <= 1'b0;
          end
          state <= S_OUT;
        end
        S_OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (io.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_preact.sv
// Directed bench for neuron_mac_preact with a wide-integer reference model.
// Results are checked against the model every valid cycle and against literals.
module tb_neuron_mac_preact;

  localparam int N   = 32;
  localparam int Q   = 16;
  localparam int LEN = 4;

  typedef struct packed {
    logic [31:0] p;
    logic        s;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic        busy;

  neuron_mac_preact_if #(.N(N)) bus();

  neuron_mac_preact #(
    .N  (N),
    .Q  (Q),
    .LEN(LEN)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bias (bias),
    .busy (busy),
    .io   (bus)
  );

  always #5 clk = ~clk;

  res_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // pure arithmetic: bias*2^Q + sum(x*w), round half up, clamp to N bits
  function automatic res_t model(input logic [31:0] b,
                                 input logic [31:0] xs[LEN],
                                 input logic [31:0] ws[LEN]);
    logic signed [127:0] a;
    logic signed [127:0] t1;
    logic signed [127:0] t2;
    logic signed [127:0] r;
    res_t o;
    a = {{96{b[31]}}, b};
    a = a * 128'sd65536;
    for (int i = 0; i < LEN; i++) begin
      t1 = {{96{xs[i][31]}}, xs[i]};
      t2 = {{96{ws[i][31]}}, ws[i]};
      a  = a + t1 * t2;
    end
    r = (a + 128'sd32768) >>> 16;
    if (r > 128'sd2147483647) begin
      o = '{p: 32'h7FFF_FFFF, s: 1'b1};
    end else if (r < -128'sd2147483648) begin
      o = '{p: 32'h8000_0000, s: 1'b1};
    end else begin
      o = '{p: r[31:0], s: 1'b0};
    end
    return o;
  endfunction

  // per-cycle compare against the model queue, plus hold stability
  initial begin
    logic [31:0] prev_p;
    logic        prev_s;
    logic        prev_hold;
    prev_p = '0;
    prev_s = 1'b0;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk1("spurious_out_valid", 1'b1, 1'b0);
        end else begin
          chk("model_pre_act", bus.pre_act, exp_q[0].p);
          chk1("model_sat", bus.sat, exp_q[0].s);
        end
        if (prev_hold) begin
          chk("hold_pre_act", bus.pre_act, prev_p);
          chk1("hold_sat", bus.sat, prev_s);
        end
        prev_p    = bus.pre_act;
        prev_s    = bus.sat;
        prev_hold = !bus.out_ready;
        if (bus.out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic run(input string nm, input logic [31:0] b,
                     input logic [31:0] xs[LEN],
                     input logic [31:0] ws[LEN],
                     input logic [31:0] lit_p, input logic lit_s,
                     input bit gaps, input int hold, input bit poke);
    exp_q.push_back(model(b, xs, ws));
    @(posedge clk); #1;
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    start = 1'b0;
    bias  = $urandom;
    chk1({nm, "_in_ready"}, bus.in_ready, 1'b1);
    for (int i = 0; i < LEN; i++) begin
      bus.in_valid = 1'b1;
      bus.x = xs[i];
      bus.w = ws[i];
      @(posedge clk); #1;
      if (gaps && i < LEN - 1) begin
        bus.in_valid = 1'b0;
        bus.x = $urandom;
        bus.w = $urandom;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.x = $urandom;
    bus.w = $urandom;
    chk1({nm, "_in_ready_drain"}, bus.in_ready, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1({nm, "_early_valid"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk1({nm, "_latency_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_pre_act"}, bus.pre_act, lit_p);
    chk1({nm, "_sat"}, bus.sat, lit_s);
    for (int k = 0; k < hold; k++) begin
      start = poke && (k == 2);
      @(posedge clk); #1;
    end
    start = poke;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    chk1({nm, "_valid_drop"}, bus.out_valid, 1'b0);
    chk1({nm, "_idle"}, busy, 1'b0);
    @(posedge clk); #1;
    chk1({nm, "_start_ignored"}, busy, 1'b0);
  endtask

  task automatic chk_reset(input string nm);
    chk1({nm, "_out_valid"}, bus.out_valid, 1'b0);
    chk1({nm, "_in_ready"}, bus.in_ready, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_pre_act"}, bus.pre_act, 32'h0);
    chk1({nm, "_sat"}, bus.sat, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xa[LEN];
    logic [31:0] wa[LEN];
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.w         = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    xa = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    wa = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
    run("c1", 32'h0, xa, wa, 32'h0002_0000, 1'b0, 1'b0, 0, 1'b0);

    xa = '{32'hFFFE_8000, 32'h0, 32'h0, 32'h0};
    wa = '{32'h0002_0000, 32'h0, 32'h0, 32'h0};
    run("c2", 32'h0000_4000, xa, wa, 32'hFFFD_4000, 1'b0, 1'b0, 1, 1'b0);

    xa = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    wa = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run("c3_pos", 32'h0, xa, wa, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 1'b0);

    wa = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    run("c3_neg", 32'h0, xa, wa, 32'h8000_0000, 1'b1, 1'b0, 0, 1'b0);

    xa = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
    wa = '{32'h0000_8000, 32'h0, 32'h0, 32'h0};
    run("c4_half", 32'h0, xa, wa, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);

    wa = '{32'h0000_7FFF, 32'h0, 32'h0, 32'h0};
    run("c4_below", 32'h0, xa, wa, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);

    xa = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    wa = '{32'h0000_8000, 32'h0, 32'h0, 32'h0};
    run("c4_neg_half", 32'h0, xa, wa, 32'h0000_0000, 1'b0, 1'b0, 0, 1'b0);

    xa = '{32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    wa = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
    run("c5", 32'h0, xa, wa, 32'h0002_0000, 1'b0, 1'b1, 5, 1'b1);

    // abort after two beats; nothing from this run may appear
    @(posedge clk); #1;
    start = 1'b1;
    bias  = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.x = 32'h0001_0000;
      bus.w = 32'h0000_8000;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk_reset("c6_abort");
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk1("c6_no_stale_valid", bus.out_valid, 1'b0);
    run("c6", 32'h0, xa, wa, 32'h0002_0000, 1'b0, 1'b0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
